bridge_fifo_leaf: RTL

BRIDGE_FIFO_LEAF -- requirements
Module: bridge_fifo_leaf

---
 rtl/bridge_fifo_leaf_pkg.sv | 31 +++
 rtl/bridge_if.sv | 13 +
 rtl/bridge_fifo_leaf_sync_fifo.sv | 52 +++++
 rtl/bridge_fifo_leaf.sv | 81 ++++++++
 4 files changed

// File: rtl/bridge_fifo_leaf_pkg.sv
// rtl/bridge_fifo_leaf_pkg.sv - shared bridge types, FIFO leaf register map and STATUS layout
package bridge_fifo_leaf_pkg;

  typedef logic [31:0] bridge_addr_t;
  typedef logic [31:0] bridge_data_t;

  localparam logic [1:0] FIFO_DATA    = 2'd0;
  localparam logic [1:0] FIFO_STATUS  = 2'd1;
  localparam logic [1:0] FIFO_CONTROL = 2'd2;

  localparam int STAT_COUNT_W  = 9;
  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_OVERFLOW = 31;

  localparam int CTRL_FLUSH     = 0;
  localparam int CTRL_CLEAR_OVF = 1;

  function automatic bridge_data_t status_word(input logic [STAT_COUNT_W-1:0] count,
                                               input logic empty, input logic full,
                                               input logic overflow);
    bridge_data_t w;
    w = '0;
    w[STAT_COUNT_W-1:0] = count;
    w[STAT_EMPTY]       = empty;
    w[STAT_FULL]        = full;
    w[STAT_OVERFLOW]    = overflow;
    return w;
  endfunction

endpackage

// File: rtl/bridge_if.sv
// rtl/bridge_if.sv - register bridge connection between a parent tree node and its leaves
interface bridge_if;
  import bridge_fifo_leaf_pkg::*;

  bridge_addr_t addr;
  bridge_data_t wr_data;
  logic         wr;
  logic         rd;
  bridge_data_t rd_data;

  modport leaf (input addr, input wr_data, input wr, input rd, output rd_data);
  modport root (output addr, output wr_data, output wr, output rd, input rd_data);
endinterface

// File: rtl/bridge_fifo_leaf_sync_fifo.sv
// rtl/bridge_fifo_leaf_sync_fifo.sv - synchronous FIFO with flush; head word is zero while empty
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO refuses the write even if the head leaves in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bridge_fifo_leaf.sv
// rtl/bridge_fifo_leaf.sv - bridge leaf exposing a write FIFO towards the core plus STATUS/CONTROL
module bridge_fifo_leaf
  import bridge_fifo_leaf_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 16
) (
  input  logic         clk,
  input  logic         reset,
  bridge_if.leaf       bridge,
  output logic         out_valid,
  output logic [31:0]  out_data,
  input  logic         out_ready,
  output logic         overflow_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          hit;
  logic [1:0]    offset;
  logic          data_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          clear_ovf;
  logic          overflow;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  bridge_data_t  status;
  bridge_data_t  rd_value;
  logic          unused_addr_bits;

  assign hit              = (bridge.addr[31:4] == BASE_ADDR[31:4]);
  assign offset           = bridge.addr[3:2];
  assign unused_addr_bits = ^bridge.addr[1:0];

  assign data_wr   = bridge.wr && hit && (offset == FIFO_DATA);
  assign ctrl_wr   = bridge.wr && hit && (offset == FIFO_CONTROL);
  assign flush     = ctrl_wr && bridge.wr_data[CTRL_FLUSH];
  assign clear_ovf = ctrl_wr && bridge.wr_data[CTRL_CLEAR_OVF];

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .push_data (bridge.wr_data),
    .pop       (out_valid && out_ready),
    .flush     (flush),
    .head      (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid    = !empty;
  assign overflow_irq = overflow;

  // STATUS reflects the state before any write in this cycle lands.
  assign status   = status_word(STAT_COUNT_W'(count), empty, full, overflow);
  assign rd_value = (hit && offset == FIFO_STATUS) ? status : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end else if (data_wr && full && !flush) begin
      overflow <= 1'b1;
    end
  end

  // Zero outside the response cycle so sibling leaves can be OR-ed by the parent.
  always_ff @(posedge clk) begin
    if (reset) begin
      bridge.rd_data <= '0;
    end else begin
      bridge.rd_data <= bridge.rd ? rd_value : '0;
    end
  end

endmodule
